// File: rtl/snn_pkg.sv
// Shared definitions for the spiking-network blocks: default widths, address
// width helper and a saturating add used by the plasticity logic.
package snn_pkg;

    localparam int SNN_W  = 16;
    localparam int SNN_TW = 4;

    typedef struct packed {
        logic               sat;
        logic signed [63:0] val;
    } sat_res_t;

    // Index width for n entries, never narrower than one bit.
    function automatic int calc_aw(input int n);
        int aw;
        aw = $clog2(n);
        if (aw < 1) begin
            aw = 1;
        end else begin
            aw = aw;
        end
        return aw;
    endfunction

    // Wide add followed by a clamp into the w-bit signed range.
    function automatic sat_res_t sat_add(input logic signed [63:0] a,
                                         input logic signed [63:0] b,
                                         input int                 w);
        logic signed [63:0] sum;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        sat_res_t           r;
        sum = a + b;
        hi  = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo  = -(64'sd1 <<< (w - 1));
        if (sum > hi) begin
            r.sat = 1'b1;
            r.val = hi;
        end else if (sum < lo) begin
            r.sat = 1'b1;
            r.val = lo;
        end else begin
            r.sat = 1'b0;
            r.val = sum;
        end
        return r;
    endfunction

endpackage

// File: rtl/stdp_synapse.sv
// One off-diagonal synaptic weight: potentiation, depression, decay toward
// zero and a direct write, with saturation reported for the sticky flag.
module stdp_synapse
    import snn_pkg::*;
#(
    parameter int W        = SNN_W,
    parameter int LTP_STEP = 1,
    parameter int LTD_STEP = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                learn_en,
    input  logic                pot,
    input  logic                dep,
    input  logic                dec_tick,
    input  logic                wr_en,
    input  logic signed [W-1:0] wr_data,
    output logic signed [W-1:0] weight,
    output logic                clamp
);

    localparam logic signed [W+1:0] LTP_V = (W+2)'(LTP_STEP);
    localparam logic signed [W+1:0] LTD_V = (W+2)'(LTD_STEP);
    localparam logic signed [W+1:0] ONE_V = (W+2)'(1);
    localparam logic signed [W+1:0] NEG_V = {(W+2){1'b1}};

    logic signed [W-1:0] weight_r;
    logic signed [W+1:0] delta_s;
    logic signed [W+1:0] decay_s;
    sat_res_t            res_s;

    // Signed step for this cycle; decay pulls one unit toward zero.
    always_comb begin
        decay_s = '0;
        if (dec_tick && (weight_r != '0)) begin
            decay_s = weight_r[W-1] ? ONE_V : NEG_V;
        end else begin
            decay_s = '0;
        end
        delta_s = (pot ? LTP_V : '0) - (dep ? LTD_V : '0) + decay_s;
        res_s   = sat_add(64'(weight_r), 64'(delta_s), W);
    end

    // Weight register; a write wins over learning for this element.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            weight_r <= '0;
        end else if (wr_en) begin
            weight_r <= wr_data;
        end else if (learn_en) begin
            weight_r <= res_s.val[W-1:0];
        end
    end

    assign weight = weight_r;
    assign clamp  = learn_en & ~wr_en & res_s.sat;

endmodule

// File: rtl/stdp_learning.sv
// N x N trace-based STDP weight matrix with saturation, optional decay and a
// random-access write/read port; the diagonal is hard-wired to zero.
module stdp_learning
    import snn_pkg::*;
#(
    parameter int N            = 7,
    parameter int W            = SNN_W,
    parameter int TW           = SNN_TW,
    parameter int TRACE_MAX    = 15,
    parameter int LTP_STEP     = 1,
    parameter int LTD_STEP     = 1,
    parameter int DECAY_PERIOD = 0,
    localparam int AW          = calc_aw(N)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                learn_en,
    input  logic [N-1:0]        spikes,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_row,
    input  logic [AW-1:0]       wr_col,
    input  logic signed [W-1:0] wr_data,
    input  logic                rd_en,
    input  logic [AW-1:0]       rd_row,
    input  logic [AW-1:0]       rd_col,
    output logic                rd_valid,
    output logic signed [W-1:0] rd_data,
    output logic [N*N*W-1:0]    weights_flat,
    output logic                sat_flag,
    input  logic                sat_clr
);

    localparam int            IW     = calc_aw(N * N);
    localparam int            DCW    = calc_aw(DECAY_PERIOD);
    localparam logic [TW-1:0] TMAX_V = TW'(TRACE_MAX);
    localparam logic [DCW-1:0] DC_LAST = DCW'((DECAY_PERIOD > 0) ? (DECAY_PERIOD - 1) : 0);

    logic [TW-1:0]       trace_r [N];
    logic [N-1:0]        trace_nz_s;
    logic [DCW-1:0]      dcnt_r;
    logic                tick_s;
    logic signed [W-1:0] wmat_s [N*N];
    logic [N*N-1:0]      clamp_s;
    logic [IW-1:0]       rd_idx_s;
    logic                rd_in_range_s;
    logic signed [W-1:0] rd_word_s;
    logic                rd_valid_r;
    logic signed [W-1:0] rd_data_r;
    logic                sat_flag_r;

    // Per-neuron traces: reload on spike, otherwise count down to zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < N; k++) begin
                trace_r[k] <= '0;
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                if (spikes[k]) begin
                    trace_r[k] <= TMAX_V;
                end else if (trace_r[k] != '0) begin
                    trace_r[k] <= trace_r[k] - TW'(1);
                end
            end
        end
    end

    always_comb begin
        for (int k = 0; k < N; k++) begin
            trace_nz_s[k] = (trace_r[k] != '0);
        end
    end

    // Decay period counter, advancing only while learning is enabled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dcnt_r <= '0;
        end else if ((DECAY_PERIOD > 0) && learn_en) begin
            dcnt_r <= (dcnt_r == DC_LAST) ? '0 : (dcnt_r + DCW'(1));
        end
    end

    assign tick_s = (DECAY_PERIOD > 0) && learn_en && (dcnt_r == DC_LAST);

    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            if (i == j) begin : g_diag
                assign wmat_s[i*N+j]  = '0;
                assign clamp_s[i*N+j] = 1'b0;
            end else begin : g_syn
                stdp_synapse #(
                    .W        (W),
                    .LTP_STEP (LTP_STEP),
                    .LTD_STEP (LTD_STEP)
                ) u_syn (
                    .clk      (clk),
                    .reset_n  (reset_n),
                    .learn_en (learn_en),
                    .pot      (spikes[j] & trace_nz_s[i]),
                    .dep      (spikes[i] & trace_nz_s[j]),
                    .dec_tick (tick_s),
                    .wr_en    (wr_en && (wr_row == AW'(i)) && (wr_col == AW'(j))),
                    .wr_data  (wr_data),
                    .weight   (wmat_s[i*N+j]),
                    .clamp    (clamp_s[i*N+j])
                );
            end
            assign weights_flat[(i*N+j)*W +: W] = wmat_s[i*N+j];
        end
    end

    // Read mux; out-of-range addresses return zero.
    always_comb begin
        rd_idx_s      = IW'(rd_row) * IW'(N) + IW'(rd_col);
        rd_in_range_s = ({1'b0, rd_row} < (AW+1)'(N)) && ({1'b0, rd_col} < (AW+1)'(N));
        rd_word_s     = '0;
        if (rd_in_range_s) begin
            rd_word_s = wmat_s[rd_idx_s];
        end else begin
            rd_word_s = '0;
        end
    end

    // Registered read port; data holds when no read is requested.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_valid_r <= 1'b0;
            rd_data_r  <= '0;
        end else if (rd_en) begin
            rd_valid_r <= 1'b1;
            rd_data_r  <= rd_word_s;
        end else begin
            rd_valid_r <= 1'b0;
        end
    end

    // Sticky saturation flag; a new clamp outranks a clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sat_flag_r <= 1'b0;
        end else if (|clamp_s) begin
            sat_flag_r <= 1'b1;
        end else if (sat_clr) begin
            sat_flag_r <= 1'b0;
        end
    end

    assign rd_valid = rd_valid_r;
    assign rd_data  = rd_data_r;
    assign sat_flag = sat_flag_r;

endmodule

// File: tb/tb_stdp_learning.sv
// Directed bench: a 4-neuron instance without decay and a 5-neuron instance
// with DECAY_PERIOD=4, both W=8, TRACE_MAX=3, LTP=2, LTD=1.
module tb_stdp_learning;

    logic              clk;
    logic              reset_n;
    logic              learn_en_a, learn_en_b;
    logic [3:0]        spikes_a;
    logic [4:0]        spikes_b;
    logic              wr_en_a, wr_en_b;
    logic [2:0]        wr_row, wr_col;
    logic signed [7:0] wr_data;
    logic              rd_en;
    logic [2:0]        rd_row, rd_col;
    logic              sat_clr;
    logic              rd_valid_a, rd_valid_b;
    logic signed [7:0] rd_data_a, rd_data_b;
    logic [127:0]      weights_a;
    logic [199:0]      weights_b;
    logic              sat_a, sat_b;

    int checks = 0;
    int errors = 0;

    stdp_learning #(
        .N(4), .W(8), .TW(4), .TRACE_MAX(3), .LTP_STEP(2), .LTD_STEP(1), .DECAY_PERIOD(0)
    ) dut_a (
        .clk(clk), .reset_n(reset_n), .learn_en(learn_en_a), .spikes(spikes_a),
        .wr_en(wr_en_a), .wr_row(wr_row[1:0]), .wr_col(wr_col[1:0]), .wr_data(wr_data),
        .rd_en(rd_en), .rd_row(rd_row[1:0]), .rd_col(rd_col[1:0]),
        .rd_valid(rd_valid_a), .rd_data(rd_data_a), .weights_flat(weights_a),
        .sat_flag(sat_a), .sat_clr(sat_clr)
    );

    stdp_learning #(
        .N(5), .W(8), .TW(4), .TRACE_MAX(3), .LTP_STEP(2), .LTD_STEP(1), .DECAY_PERIOD(4)
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .learn_en(learn_en_b), .spikes(spikes_b),
        .wr_en(wr_en_b), .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data),
        .rd_en(rd_en), .rd_row(rd_row), .rd_col(rd_col),
        .rd_valid(rd_valid_b), .rd_data(rd_data_b), .weights_flat(weights_b),
        .sat_flag(sat_b), .sat_clr(sat_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    function automatic logic signed [7:0] wget(input logic [199:0] flat, input int n,
                                               input int i, input int j);
        return flat[(i*n+j)*8 +: 8];
    endfunction

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0; learn_en_a = 1'b0; learn_en_b = 1'b0;
        spikes_a = 4'b0; spikes_b = 5'b0; wr_en_a = 1'b0; wr_en_b = 1'b0;
        wr_row = 3'd0; wr_col = 3'd0; wr_data = 8'sd0;
        rd_en = 1'b0; rd_row = 3'd0; rd_col = 3'd0; sat_clr = 1'b0;
        tick(); tick();
        check("rst_weights_a", 32'(|weights_a), 0);
        check("rst_rd_valid_a", 32'(rd_valid_a), 0);
        check("rst_sat_a", 32'(sat_a), 0);
        check("rst_rd_data_a", rd_data_a, 0);
        reset_n = 1'b1;
        tick();

        // Pre 0 then post 1 on the next cycle
        learn_en_a = 1'b1;
        spikes_a = 4'b0001; tick();
        spikes_a = 4'b0010; tick();
        check("pair_w01", wget(200'(weights_a), 4, 0, 1), 2);
        check("pair_w10", wget(200'(weights_a), 4, 1, 0), -1);
        spikes_a = 4'b0000; repeat (4) tick();
        // Same pairing with a 4-cycle gap: trace has expired
        spikes_a = 4'b0001; tick();
        spikes_a = 4'b0000; repeat (3) tick();
        spikes_a = 4'b0010; tick();
        check("gap_w01", wget(200'(weights_a), 4, 0, 1), 2);
        check("gap_w10", wget(200'(weights_a), 4, 1, 0), -1);
        spikes_a = 4'b0000; repeat (4) tick();

        // Saturation at the positive limit
        wr_en_a = 1'b1; wr_row = 3'd2; wr_col = 3'd3; wr_data = 8'sd126; tick();
        wr_en_a = 1'b0;
        check("wr_w23", wget(200'(weights_a), 4, 2, 3), 126);
        spikes_a = 4'b0100; tick();
        spikes_a = 4'b1000; tick();
        check("sat1_w23", wget(200'(weights_a), 4, 2, 3), 127);
        check("sat1_w32", wget(200'(weights_a), 4, 3, 2), -1);
        check("sat1_flag", 32'(sat_a), 1);
        spikes_a = 4'b0000; sat_clr = 1'b1; tick();
        sat_clr = 1'b0;
        check("satclr_flag", 32'(sat_a), 0);
        repeat (3) tick();
        spikes_a = 4'b0100; tick();
        spikes_a = 4'b1000; sat_clr = 1'b1; tick();
        check("sat2_w23", wget(200'(weights_a), 4, 2, 3), 127);
        check("sat2_w32", wget(200'(weights_a), 4, 3, 2), -2);
        check("sat2_set_wins", 32'(sat_a), 1);
        spikes_a = 4'b0000; tick();
        sat_clr = 1'b0;
        check("sat2_clr", 32'(sat_a), 0);

        // Diagonal write is ignored
        wr_en_a = 1'b1; wr_row = 3'd2; wr_col = 3'd2; wr_data = 8'sd5; tick();
        wr_en_a = 1'b0;
        check("diag_w22", wget(200'(weights_a), 4, 2, 2), 0);
        rd_en = 1'b1; rd_row = 3'd2; rd_col = 3'd2; tick();
        rd_en = 1'b0;
        check("diag_rd_valid", 32'(rd_valid_a), 1);
        check("diag_rd_data", rd_data_a, 0);
        repeat (3) tick();

        // All fire from quiet traces, then all fire again
        spikes_a = 4'b1111; tick();
        check("all1_w01", wget(200'(weights_a), 4, 0, 1), 2);
        check("all1_w32", wget(200'(weights_a), 4, 3, 2), -2);
        tick();
        spikes_a = 4'b0000;
        check("all2_w01", wget(200'(weights_a), 4, 0, 1), 3);
        check("all2_w10", wget(200'(weights_a), 4, 1, 0), 0);
        check("all2_w12", wget(200'(weights_a), 4, 1, 2), 1);
        check("all2_w32", wget(200'(weights_a), 4, 3, 2), -1);
        check("all2_w23", wget(200'(weights_a), 4, 2, 3), 127);
        check("all2_w00", wget(200'(weights_a), 4, 0, 0), 0);
        check("all2_w33", wget(200'(weights_a), 4, 3, 3), 0);
        check("all2_sat", 32'(sat_a), 1);

        // Read and write the same element in one cycle
        rd_en = 1'b1; rd_row = 3'd1; rd_col = 3'd2;
        wr_en_a = 1'b1; wr_row = 3'd1; wr_col = 3'd2; wr_data = 8'sd9; tick();
        wr_en_a = 1'b0;
        check("rw_valid", 32'(rd_valid_a), 1);
        check("rw_old", rd_data_a, 1);
        check("rw_w12", wget(200'(weights_a), 4, 1, 2), 9);
        tick();
        check("rd_new", rd_data_a, 9);
        rd_en = 1'b0; tick();
        check("rd_idle_valid", 32'(rd_valid_a), 0);
        check("rd_idle_hold", rd_data_a, 9);
        learn_en_a = 1'b0;

        // Decay on the second instance
        wr_en_b = 1'b1; wr_row = 3'd0; wr_col = 3'd1; wr_data = 8'sd5; tick();
        wr_row = 3'd1; wr_col = 3'd0; wr_data = -8'sd3; tick();
        wr_en_b = 1'b0;
        learn_en_b = 1'b1; repeat (3) tick();
        check("dec3_w01", wget(weights_b, 5, 0, 1), 5);
        tick();
        check("dec4_w01", wget(weights_b, 5, 0, 1), 4);
        check("dec4_w10", wget(weights_b, 5, 1, 0), -2);
        learn_en_b = 1'b0; repeat (10) tick();
        check("hold_w01", wget(weights_b, 5, 0, 1), 4);
        check("hold_w10", wget(weights_b, 5, 1, 0), -2);
        learn_en_b = 1'b1; repeat (4) tick();
        learn_en_b = 1'b0;
        check("dec8_w01", wget(weights_b, 5, 0, 1), 3);
        check("dec8_w10", wget(weights_b, 5, 1, 0), -1);
        rd_en = 1'b1; rd_row = 3'd0; rd_col = 3'd1; tick();
        check("b_rd_valid", 32'(rd_valid_b), 1);
        check("b_rd_data", rd_data_b, 3);
        rd_row = 3'd5; rd_col = 3'd0; tick();
        rd_en = 1'b0;
        check("b_oor_valid", 32'(rd_valid_b), 1);
        check("b_oor_data", rd_data_b, 0);

        // Asynchronous reset mid-operation
        reset_n = 1'b0; #2;
        check("mid_rst_wa", 32'(|weights_a), 0);
        check("mid_rst_wb", 32'(|weights_b), 0);
        check("mid_rst_sat", 32'(sat_a), 0);
        check("mid_rst_rd", rd_data_a, 0);
        reset_n = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
